// File: rtl/rx_sync_pkg.sv
// rx_sync_pkg
//   Shared definitions for the receive-side link synchroniser:
//   - state encoding of the link FSM (2'b11 is unused and recovers to SEARCH)
//   - default COM / IDLE symbol values
//   - counter widths for the COM-run, miss and error counters
package rx_sync_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'b00,
    ST_SYNC   = 2'b01,
    ST_ACTIVE = 2'b10
  } state_t;

  localparam logic [7:0] COM_SYMBOL_DEF  = 8'hBC;
  localparam logic [7:0] IDLE_SYMBOL_DEF = 8'h7C;

  // com_cnt / miss_cnt width; limits up to 15 fit.
  localparam int CNT_W = 4;
  // err_count width, saturates at all-ones.
  localparam int ERR_W = 8;

endpackage

// File: rtl/rx_idle_sync_sat_counter.sv
// sat_counter
//   Up-counter that stops at LIMIT instead of wrapping.
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   asynchronous, active-high reset (count -> 0)
//     inc      in   count up by one (ignored once at LIMIT)
//     clr      in   synchronous clear, wins over inc
//     cnt      out  current count [W-1:0]
//     at_limit out  cnt == LIMIT
module sat_counter #(
  parameter int W     = 4,
  parameter int LIMIT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_limit
);

  assign at_limit = (cnt == W'(LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && !at_limit)  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/rx_idle_sync.sv
// rx_idle_sync
//   Receive-side link synchroniser feeding IDLE_OUT to the recirculation
//   demux. Hunts for SYNC_COUNT consecutive valid COM symbols, then goes
//   ACTIVE and forwards payload bytes; IDLE symbols raise IDLE_OUT, payload
//   lowers it. LOSS_COUNT consecutive valid_in-low cycles while ACTIVE drop
//   the link back to SEARCH. All outputs registered, 1 clk_f latency.
//
//   Optional build macro RX_ERR_COUNT_EN adds err_count, which counts
//   ACTIVE->SEARCH losses and SYNC->SEARCH aborts (saturating at 8'hFF).
//
//   Ports:
//     clk_f      in   byte clock, rising edge
//     reset      in   asynchronous, active-high
//     data_in    in   received byte [7:0]
//     valid_in   in   data_in qualifier
//     data_out   out  forwarded payload byte [7:0], holds when valid_out=0
//     valid_out  out  data_out qualifier, only ever 1 while ACTIVE
//     active     out  link synchronised
//     IDLE_OUT   out  1 = recirculate/idle, 0 = pass traffic
//     err_count  out  link error count [7:0] (RX_ERR_COUNT_EN only)
module rx_idle_sync
  import rx_sync_pkg::*;
#(
  parameter logic [7:0] COM_SYMBOL  = COM_SYMBOL_DEF,
  parameter logic [7:0] IDLE_SYMBOL = IDLE_SYMBOL_DEF,
  parameter int         SYNC_COUNT  = 4,
  parameter int         LOSS_COUNT  = 3
) (
  input  logic       clk_f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       IDLE_OUT
`ifdef RX_ERR_COUNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  state_t           state;
  logic [CNT_W-1:0] com_cnt, miss_cnt;
  logic             com_full, miss_full;
  logic             com_inc, com_clr, miss_inc, miss_clr, err_inc;

  logic is_com, is_idle, com_rx, com_last, miss_last;

  assign is_com  = (data_in == COM_SYMBOL);
  assign is_idle = (data_in == IDLE_SYMBOL);
  assign com_rx  = valid_in && is_com;

  // "Next increment reaches the limit": lets the transition happen on the
  // same edge that samples the deciding symbol.
  assign com_last  = (com_cnt  == CNT_W'(SYNC_COUNT - 1));
  assign miss_last = (miss_cnt == CNT_W'(LOSS_COUNT - 1));

  // Counter control, decoded from the current state and input.
  always_comb begin
    com_inc  = 1'b0;
    com_clr  = 1'b0;
    miss_inc = 1'b0;
    miss_clr = 1'b0;
    err_inc  = 1'b0;
    case (state)
      ST_SEARCH: begin
        miss_clr = 1'b1;
        com_inc  = com_rx;
        com_clr  = !com_rx;
      end
      ST_SYNC: begin
        miss_clr = 1'b1;
        if (com_rx) begin
          com_inc = 1'b1;
        end else if (valid_in) begin
          com_clr = 1'b1;
          err_inc = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // com_cnt sits at SYNC_COUNT for the whole ACTIVE stay.
        if (valid_in) begin
          miss_clr = 1'b1;
        end else if (miss_last) begin
          miss_clr = 1'b1;
          com_clr  = 1'b1;
          err_inc  = 1'b1;
        end else begin
          miss_inc = 1'b1;
        end
      end
      default: begin
        com_clr  = 1'b1;
        miss_clr = 1'b1;
      end
    endcase
  end

  sat_counter #(.W(CNT_W), .LIMIT(SYNC_COUNT)) u_com_cnt (
    .clk      (clk_f),
    .rst      (reset),
    .inc      (com_inc),
    .clr      (com_clr),
    .cnt      (com_cnt),
    .at_limit (com_full)
  );

  sat_counter #(.W(CNT_W), .LIMIT(LOSS_COUNT)) u_miss_cnt (
    .clk      (clk_f),
    .rst      (reset),
    .inc      (miss_inc),
    .clr      (miss_clr),
    .cnt      (miss_cnt),
    .at_limit (miss_full)
  );

`ifdef RX_ERR_COUNT_EN
  logic err_full;

  sat_counter #(.W(ERR_W), .LIMIT((1 << ERR_W) - 1)) u_err_cnt (
    .clk      (clk_f),
    .rst      (reset),
    .inc      (err_inc),
    .clr      (1'b0),
    .cnt      (err_count),
    .at_limit (err_full)
  );

  // Saturation flags are handled inside the counters; nothing else needs them.
  logic unused_flags;
  assign unused_flags = com_full ^ miss_full ^ err_full;
`else
  logic unused_flags;
  assign unused_flags = com_full ^ miss_full ^ err_inc;
`endif

  // Link FSM with registered outputs.
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      state     <= ST_SEARCH;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
      IDLE_OUT  <= 1'b1;
    end else begin
      case (state)
        ST_SEARCH: begin
          valid_out <= 1'b0;
          active    <= 1'b0;
          IDLE_OUT  <= 1'b1;
          if (com_rx) state <= ST_SYNC;
        end
        ST_SYNC: begin
          valid_out <= 1'b0;
          IDLE_OUT  <= 1'b1;
          if (com_rx && com_last) begin
            state  <= ST_ACTIVE;
            active <= 1'b1;
          end else if (valid_in && !is_com) begin
            state <= ST_SEARCH;
          end
        end
        ST_ACTIVE: begin
          if (valid_in) begin
            if (is_com) begin
              // alignment symbol mid-link: no data, IDLE_OUT unchanged
              valid_out <= 1'b0;
            end else if (is_idle) begin
              valid_out <= 1'b0;
              IDLE_OUT  <= 1'b1;
            end else begin
              data_out  <= data_in;
              valid_out <= 1'b1;
              IDLE_OUT  <= 1'b0;
            end
          end else begin
            valid_out <= 1'b0;
            if (miss_last) begin
              state    <= ST_SEARCH;
              active   <= 1'b0;
              IDLE_OUT <= 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_SEARCH;
          valid_out <= 1'b0;
          active    <= 1'b0;
          IDLE_OUT  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_idle_sync.sv
// tb_rx_idle_sync
//   Randomised + directed bench for rx_idle_sync with an in-bench link model
//   (link-up flag, COM run length, miss run length, error tally) that
//   predicts every output each cycle. Build with RX_ERR_COUNT_EN defined to
//   cover err_count as well.
module tb_rx_idle_sync;

  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;
  localparam int SYNC_N = 4;
  localparam int LOSS_N = 3;

  logic       clk_f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       IDLE_OUT;
`ifdef RX_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  rx_idle_sync #(
    .COM_SYMBOL  (COM),
    .IDLE_SYMBOL (IDLE),
    .SYNC_COUNT  (SYNC_N),
    .LOSS_COUNT  (LOSS_N)
  ) dut (
    .clk_f     (clk_f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active),
    .IDLE_OUT  (IDLE_OUT)
`ifdef RX_ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk_f = ~clk_f;

  int total = 0;
  int bad   = 0;

  // ---------------- link model ----------------
  bit       up;      // link synchronised
  int       run;     // consecutive COMs seen while hunting
  int       miss;    // consecutive empty cycles while up
  int       err;     // aborts + losses
  logic [7:0] e_do;
  bit       e_vo, e_act, e_idle;

  task automatic model_reset();
    up = 0; run = 0; miss = 0; err = 0;
    e_do = 8'h00; e_vo = 0; e_act = 0; e_idle = 1;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    if (!up) begin
      e_vo = 0; e_idle = 1; e_act = 0;
      if (v) begin
        if (d == COM) begin
          run++;
          if (run == SYNC_N) begin up = 1; e_act = 1; miss = 0; end
        end else begin
          if (run > 0) err++;   // aborted a sync attempt
          run = 0;
        end
      end
    end else begin
      if (v) begin
        miss = 0;
        if (d == COM) e_vo = 0;
        else if (d == IDLE) begin e_vo = 0; e_idle = 1; end
        else begin e_do = d; e_vo = 1; e_idle = 0; end
      end else begin
        e_vo = 0;
        miss++;
        if (miss == LOSS_N) begin
          up = 0; run = 0; miss = 0; e_act = 0; e_idle = 1; err++;
        end
      end
    end
    if (err > 255) err = 255;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("data_out",  int'(data_out),  int'(e_do));
    chk("valid_out", int'(valid_out), int'(e_vo));
    chk("active",    int'(active),    int'(e_act));
    chk("IDLE_OUT",  int'(IDLE_OUT),  int'(e_idle));
`ifdef RX_ERR_COUNT_EN
    chk("err_count", int'(err_count), err);
`endif
  endtask

  // drive at negedge, model on posedge, compare 1 time unit later
  task automatic step(input bit v, input logic [7:0] d);
    @(negedge clk_f);
    valid_in = v;
    data_in  = d;
    @(posedge clk_f);
    if (reset) model_reset();
    else       model_step(v, d);
    #1 compare_all();
  endtask

  task automatic coms(input int n);
    for (int i = 0; i < n; i++) step(1'b1, COM);
  endtask

  task automatic async_reset_pulse();
    @(negedge clk_f);
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    @(negedge clk_f);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = 8'h00;
    model_reset();
    #1;
    chk("reset_idle",  int'(IDLE_OUT),  1);
    chk("reset_act",   int'(active),    0);
    chk("reset_do",    int'(data_out),  0);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    @(negedge clk_f);
    reset = 1'b0;

    // 4 COMs bring the link up one edge after the 4th
    coms(3);
    chk("sync3_act", int'(active), 0);
    chk("sync3_vo",  int'(valid_out), 0);
    coms(1);
    chk("sync4_act",  int'(active), 1);
    chk("sync4_idle", int'(IDLE_OUT), 1);

    // drop link, then abort a 3-COM run with 0x55, then resync
    for (int i = 0; i < LOSS_N; i++) step(1'b0, 8'h00);
    chk("loss_act", int'(active), 0);
    coms(3);
    step(1'b1, 8'h55);
    chk("abort_act", int'(active), 0);
    coms(3);
    chk("resync3_act", int'(active), 0);
    coms(1);
    chk("resync4_act", int'(active), 1);

    // idle / payload / idle
    step(1'b1, IDLE);
    chk("p0_idle", int'(IDLE_OUT), 1);
    chk("p0_vo",   int'(valid_out), 0);
    step(1'b1, 8'hA1);
    chk("p1_idle", int'(IDLE_OUT), 0);
    chk("p1_do",   int'(data_out), 8'hA1);
    step(1'b1, 8'hA2);
    chk("p2_vo",   int'(valid_out), 1);
    chk("p2_do",   int'(data_out), 8'hA2);
    step(1'b1, IDLE);
    chk("p3_idle", int'(IDLE_OUT), 1);
    chk("p3_vo",   int'(valid_out), 0);
    chk("p3_do",   int'(data_out), 8'hA2);

    // two misses survive, third consecutive miss drops
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    step(1'b1, 8'h33);
    chk("m2_act", int'(active), 1);
    chk("m2_do",  int'(data_out), 8'h33);
    chk("m2_vo",  int'(valid_out), 1);
    for (int i = 0; i < LOSS_N; i++) step(1'b0, 8'h00);
    chk("m3_act",  int'(active), 0);
    chk("m3_idle", int'(IDLE_OUT), 1);
`ifdef RX_ERR_COUNT_EN
    chk("err3", int'(err_count), 3);
`endif

    // async reset mid-payload
    coms(4);
    step(1'b1, 8'hA1);
    chk("pre_rst_do", int'(data_out), 8'hA1);
    @(negedge clk_f);
    #2 reset = 1'b1;
    #1;
    chk("async_do",   int'(data_out), 0);
    chk("async_vo",   int'(valid_out), 0);
    chk("async_act",  int'(active), 0);
    chk("async_idle", int'(IDLE_OUT), 1);
    model_reset();
    step(1'b0, 8'h00);
    @(negedge clk_f);
    reset = 1'b0;
    // a payload byte right after reset is not forwarded
    step(1'b1, 8'h44);
    chk("post_rst_vo", int'(valid_out), 0);

    // randomised traffic
    for (int n = 0; n < 4000; n++) begin
      int r;
      if ($urandom_range(0, 59) == 0) coms(SYNC_N + 1);
      if ($urandom_range(0, 799) == 0) async_reset_pulse();
      r = int'($urandom_range(0, 99));
      if (r < 40)      step($urandom_range(0, 5) != 0, COM);
      else if (r < 55) step($urandom_range(0, 5) != 0, IDLE);
      else             step($urandom_range(0, 4) != 0, 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
